// File: rtl/serial_divider_hs_if.sv
// serial_divider_hs_if: request/response handshake bundle for serial_divider_hs.
//   Request side : in_valid, in_ready, dividend, divisor
//   Response side: out_valid, out_ready, quotient, remainder, div_by_zero, overflow
//   master modport: the client that issues divides and consumes results.
//   slave modport : the divider itself.
interface serial_divider_hs_if #(
    parameter int unsigned DIVIDEND_WIDTH = 16,
    parameter int unsigned DIVISOR_WIDTH  = 8,
    parameter int unsigned QUOTIENT_WIDTH = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [QUOTIENT_WIDTH-1:0] quotient;
    logic [DIVISOR_WIDTH-1:0]  remainder;
    logic                      div_by_zero;
    logic                      overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/serial_divider_hs.sv
// serial_divider_hs: unsigned iterative restoring divider with valid/ready handshakes.
// Resolves BITS_PER_CYCLE quotient bits per BUSY cycle, MSB first; a result takes
// DIVIDEND_WIDTH / BITS_PER_CYCLE BUSY cycles regardless of operands.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   bus - serial_divider_hs_if.slave:
//         in_valid/in_ready/dividend/divisor   request (accepted only in IDLE)
//         out_valid/out_ready                  result handshake (held until accepted)
//         quotient                             saturated quotient (all ones on overflow / x/0)
//         remainder                            dividend mod divisor (low dividend bits on x/0)
//         div_by_zero, overflow                result flags
module serial_divider_hs #(
    parameter int unsigned DIVIDEND_WIDTH = 16,
    parameter int unsigned DIVISOR_WIDTH  = 8,
    parameter int unsigned QUOTIENT_WIDTH = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic                clk,
    input logic                rst,
    serial_divider_hs_if.slave bus
);
    localparam int unsigned STEPS     = DIVIDEND_WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_WIDTH = $clog2(STEPS + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e state_q, state_d;

    logic [CNT_WIDTH-1:0]      cnt_q;
    // Dividend bits leave at the top while quotient bits enter at the bottom, so after
    // STEPS cycles this register holds the exact DIVIDEND_WIDTH-bit quotient.
    logic [DIVIDEND_WIDTH-1:0] acc_q, acc_d;
    logic [DIVISOR_WIDTH-1:0]  dvs_q;
    logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
    // Low dividend bits kept aside for the divide-by-zero remainder.
    logic [DIVISOR_WIDTH-1:0]  dvd_lo_q;

    logic [QUOTIENT_WIDTH-1:0] quotient_q, quotient_d;
    logic [DIVISOR_WIDTH-1:0]  remainder_q, remainder_d;
    logic                      div_by_zero_q, div_by_zero_d;
    logic                      overflow_q, overflow_d;

    logic                      accept;
    logic                      last;
    logic [DIVISOR_WIDTH:0]    partial;
    logic                      qbit;

    assign accept = (state_q == StIdle) && bus.in_valid;
    assign last   = (state_q == StBusy) && (cnt_q == CNT_WIDTH'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.in_valid)          state_d = StBusy;
            StBusy: if (cnt_q == CNT_WIDTH'(1)) state_d = StDone;
            StDone: if (bus.out_ready)         state_d = StIdle;
            default:                           state_d = StIdle;
        endcase
    end

    // Handshake outputs, decoded from state only.
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
    end

    // BITS_PER_CYCLE restoring iterations chained within one cycle.
    always_comb begin
        rem_d   = rem_q;
        acc_d   = acc_q;
        partial = '0;
        qbit    = 1'b0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            partial = {rem_d, acc_d[DIVIDEND_WIDTH-1]};
            if (partial >= {1'b0, dvs_q}) begin
                partial = partial - {1'b0, dvs_q};
                qbit    = 1'b1;
            end else begin
                qbit    = 1'b0;
            end
            // With a nonzero divisor the kept value is below the divisor, so it fits.
            rem_d = partial[DIVISOR_WIDTH-1:0];
            acc_d = {acc_d[DIVIDEND_WIDTH-2:0], qbit};
        end
    end

    // Result shaping, consumed only on the final BUSY cycle.
    always_comb begin
        div_by_zero_d = (dvs_q == '0);
        overflow_d    = 1'b0;
        quotient_d    = QUOTIENT_WIDTH'(acc_d);
        remainder_d   = rem_d;
        if (div_by_zero_d) begin
            quotient_d  = '1;
            remainder_d = dvd_lo_q;
        end else if ((acc_d >> QUOTIENT_WIDTH) != '0) begin
            quotient_d = '1;
            overflow_d = 1'b1;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            acc_q         <= '0;
            dvs_q         <= '0;
            rem_q         <= '0;
            dvd_lo_q      <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q    <= CNT_WIDTH'(STEPS);
                acc_q    <= bus.dividend;
                dvs_q    <= bus.divisor;
                rem_q    <= '0;
                dvd_lo_q <= DIVISOR_WIDTH'(bus.dividend);
            end else if (state_q == StBusy) begin
                cnt_q <= cnt_q - CNT_WIDTH'(1);
                acc_q <= acc_d;
                rem_q <= rem_d;
            end
            if (last) begin
                quotient_q    <= quotient_d;
                remainder_q   <= remainder_d;
                div_by_zero_q <= div_by_zero_d;
                overflow_q    <= overflow_d;
            end
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_serial_divider_hs.sv
// Testbench for serial_divider_hs: runs a 1-bit/cycle and a 4-bit/cycle instance in lockstep
// on identical requests; a negedge monitor checks each result against a queued expectation.
module tb_serial_divider_hs;
    typedef struct packed {
        logic [7:0] quot;
        logic [7:0] rem;
        logic       dz;
        logic       of;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [1:0]  rdy;
    bit          rand_rdy = 1'b0;

    logic [1:0]  ov;
    logic [1:0]  ir;
    res_t        act [2];

    res_t        exp_q [2][$];
    res_t        held [2];
    logic [1:0]  holding = '0;
    int          exp_lat [2] = '{16, 4};
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    serial_divider_hs_if #(.DIVIDEND_WIDTH(16), .DIVISOR_WIDTH(8), .QUOTIENT_WIDTH(8)) bus1 ();
    serial_divider_hs_if #(.DIVIDEND_WIDTH(16), .DIVISOR_WIDTH(8), .QUOTIENT_WIDTH(8)) bus4 ();

    serial_divider_hs #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    serial_divider_hs #(.BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    assign bus1.in_valid  = in_valid;
    assign bus1.dividend  = dividend;
    assign bus1.divisor   = divisor;
    assign bus1.out_ready = rdy[0];
    assign bus4.in_valid  = in_valid;
    assign bus4.dividend  = dividend;
    assign bus4.divisor   = divisor;
    assign bus4.out_ready = rdy[1];

    assign ov     = {bus4.out_valid, bus1.out_valid};
    assign ir     = {bus4.in_ready, bus1.in_ready};
    assign act[0] = {bus1.quotient, bus1.remainder, bus1.div_by_zero, bus1.overflow};
    assign act[1] = {bus4.quotient, bus4.remainder, bus4.div_by_zero, bus4.overflow};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    function automatic res_t mk(input int q, input int r, input bit dz, input bit of);
        res_t m;
        m.quot = 8'(q);
        m.rem  = 8'(r);
        m.dz   = dz;
        m.of   = of;
        return m;
    endfunction

    // Reference: plain integer division plus saturation rules.
    function automatic res_t model(input logic [15:0] a, input logic [7:0] b);
        int unsigned qq;
        if (b == 8'd0) return mk(255, int'(a[7:0]), 1'b1, 1'b0);
        qq = int'(a) / int'(b);
        if (qq > 255) return mk(255, int'(a) % int'(b), 1'b0, 1'b1);
        return mk(int'(qq), int'(a) % int'(b), 1'b0, 1'b0);
    endfunction

    // Random back-pressure, mostly ready.
    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            rdy[0] = ($urandom_range(0, 3) != 0);
            rdy[1] = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks results at handshake and stability while stalled.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            holding = '0;
            exp_q[0].delete();
            exp_q[1].delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (holding[i]) begin
                    check($sformatf("hold[%0d]", i), 64'({ov[i], act[i]}),
                          64'({1'b1, held[i]}));
                end
                holding[i] = 1'b0;
                if (ov[i]) begin
                    if (rdy[i]) begin
                        if (exp_q[i].size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL result[%0d]: got 0x%0h, expected no result", i,
                                     act[i]);
                        end else begin
                            e = exp_q[i].pop_front();
                            check($sformatf("result[%0d]", i), 64'(act[i]), 64'(e));
                        end
                    end else begin
                        holding[i] = 1'b1;
                        held[i]    = act[i];
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (ir != 2'b11 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_wait", 64'(ir), 64'(2'b11));
    endtask

    // Issues one request to both instances and measures accept-to-out_valid latency.
    task automatic issue(input logic [15:0] a, input logic [7:0] b, input bit pulse);
        int   lat [2];
        int   n;
        res_t e;
        wait_idle();
        e = model(a, b);
        exp_q[0].push_back(e);
        exp_q[1].push_back(e);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_not_ready", 64'(ir), 64'(2'b00));
        lat = '{-1, -1};
        n   = 0;
        while ((lat[0] < 0 || lat[1] < 0) && n < 100) begin
            for (int i = 0; i < 2; i++) if (ov[i] && lat[i] < 0) lat[i] = n;
            if (lat[0] < 0 || lat[1] < 0) begin
                // Stray request while busy must be ignored.
                if (pulse && n == 2) begin
                    in_valid = 1'b1;
                    dividend = 16'($urandom);
                    divisor  = 8'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
                @(posedge clk);
                #1;
                n++;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) check($sformatf("latency[%0d]", i), 64'(lat[i]),
                                          64'(exp_lat[i]));
    endtask

    task automatic check_idle_outputs(input string name, input res_t want);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check($sformatf("%s[%0d]", name, i), 64'(act[i]), 64'(want));
    endtask

    initial begin
        logic [7:0] b;
        rst      = 1'b1;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        rdy      = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset[%0d]", i), 64'({ir[i], ov[i], act[i]}),
                  64'({1'b1, 1'b0, 18'd0}));
        end

        rdy = 2'b11;
        issue(16'd1000, 8'd7, 1'b0);
        check_idle_outputs("q1000_7", mk(142, 6, 1'b0, 1'b0));
        issue(16'd65535, 8'd1, 1'b0);
        check_idle_outputs("q65535_1", mk(255, 0, 1'b0, 1'b1));
        issue(16'd1234, 8'd0, 1'b0);
        check_idle_outputs("q1234_0", mk(255, 8'hD2, 1'b1, 1'b0));

        // Back-pressure: results held 5 cycles, stray requests ignored.
        rdy = 2'b00;
        issue(16'd200, 8'd9, 1'b1);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k < 4);
            check("done_not_ready", 64'(ir), 64'(2'b00));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rdy      = 2'b11;
        @(posedge clk);
        #1;
        check("ready_after_hs", 64'({ir, ov}), 64'(4'b1100));
        for (int i = 0; i < 2; i++) check($sformatf("q200_9[%0d]", i), 64'(act[i]),
                                          64'(mk(22, 2, 1'b0, 1'b0)));

        // Randomized sweep with random back-pressure.
        rand_rdy = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            case ($urandom_range(0, 3))
                0:       b = 8'($urandom_range(0, 3));
                default: b = 8'($urandom);
            endcase
            issue(16'($urandom), b, 1'b0);
        end
        rand_rdy = 1'b0;
        rdy      = 2'b11;
        repeat (30) @(posedge clk);
        #1;

        // Reset during the 8th BUSY cycle aborts the request.
        rdy = 2'b00;
        wait_idle();
        in_valid = 1'b1;
        dividend = 16'd5000;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("busy_before_abort", 64'(ir[0]), 64'(1'b0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("abort[%0d]", i), 64'({ir[i], ov[i], act[i]}),
                  64'({1'b1, 1'b0, 18'd0}));
        end
        rdy = 2'b11;
        repeat (20) @(posedge clk);
        #1;
        check("no_result_after_abort", 64'(ov), 64'(2'b00));
        issue(16'd100, 8'd10, 1'b0);
        check_idle_outputs("q100_10", mk(10, 0, 1'b0, 1'b0));

        repeat (5) @(posedge clk);
        #1;
        check("drain[0]", 64'(exp_q[0].size()), 64'(0));
        check("drain[1]", 64'(exp_q[1].size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
